// File: rtl/get_length_multi.sv
// Iterative bit-length finder: scans the operand one CHUNK at a time, MSB chunk first.
// Define GET_LENGTH_MULTI_ONEHOT_EN to add msb_out, a one-hot of the highest set bit.
module get_length_multi #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             md_start,
    input  logic [WIDTH-1:0] num_in,
    output logic [LEN_W-1:0] len_out,
    output logic             md_end,
    output logic             busy
`ifdef GET_LENGTH_MULTI_ONEHOT_EN
    ,
    output logic [WIDTH-1:0] msb_out
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int POS_W  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] num_q,   num_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [LEN_W-1:0] len_q,   len_d;

    logic [CHUNK-1:0] chunk;
    logic             chunk_nz;
    logic [POS_W-1:0] hi_pos;
    logic [LEN_W-1:0] scan_len;

`ifdef GET_LENGTH_MULTI_ONEHOT_EN
    logic [WIDTH-1:0] msb_q, msb_d;
`endif

    // Chunk under examination and the position of its highest set bit.
    always_comb begin
        chunk    = CHUNK'(num_q >> (int'(idx_q) * CHUNK));
        chunk_nz = |chunk;
        hi_pos   = '0;
        for (int b = 0; b < CHUNK; b++) begin
            if (chunk[b]) hi_pos = POS_W'(b);
        end
        scan_len = LEN_W'(int'(idx_q) * CHUNK) + LEN_W'(hi_pos) + LEN_W'(1);
    end

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = idx_q;
        len_d   = len_q;
`ifdef GET_LENGTH_MULTI_ONEHOT_EN
        msb_d   = msb_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (md_start) begin
                    num_d   = num_in;
                    idx_d   = IDX_W'(NCHUNK - 1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (chunk_nz) begin
                    len_d   = scan_len;
`ifdef GET_LENGTH_MULTI_ONEHOT_EN
                    msb_d   = {{(WIDTH-1){1'b0}}, 1'b1} << (int'(idx_q) * CHUNK + int'(hi_pos));
`endif
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    len_d   = '0;
`ifdef GET_LENGTH_MULTI_ONEHOT_EN
                    msb_d   = '0;
`endif
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
`ifdef GET_LENGTH_MULTI_ONEHOT_EN
            msb_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
`ifdef GET_LENGTH_MULTI_ONEHOT_EN
            msb_q   <= msb_d;
`endif
        end
    end

    assign len_out = len_q;
    assign md_end  = (state_q == DONE);
    assign busy    = (state_q != IDLE);
`ifdef GET_LENGTH_MULTI_ONEHOT_EN
    assign msb_out = msb_q;
`endif

endmodule

// File: tb/tb_get_length_multi.sv
// Self-checking bench for get_length_multi: directed cases plus randomized traffic
// compared every cycle against a transaction-level model of bit length and latency.
module tb_get_length_multi;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 8;
    localparam int LEN_W  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rstn;
    logic             md_start;
    logic [WIDTH-1:0] num_in;
    logic [LEN_W-1:0] len_out;
    logic             md_end;
    logic             busy;
`ifdef GET_LENGTH_MULTI_ONEHOT_EN
    logic [WIDTH-1:0] msb_out;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    get_length_multi #(.WIDTH(WIDTH), .CHUNK(CHUNK), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .md_start (md_start),
        .num_in   (num_in),
        .len_out  (len_out),
        .md_end   (md_end),
        .busy     (busy)
`ifdef GET_LENGTH_MULTI_ONEHOT_EN
        ,
        .msb_out  (msb_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int bit_len(input logic [WIDTH-1:0] v);
        int r = 0;
        for (int i = 0; i < WIDTH; i++) if (v[i]) r = i + 1;
        return r;
    endfunction

    function automatic int chunks_scanned(input int len);
        return (len == 0) ? NCHUNK : NCHUNK - (len - 1) / CHUNK;
    endfunction

    function automatic logic [WIDTH-1:0] onehot_of(input int len);
        logic [WIDTH-1:0] one = 1;
        return (len == 0) ? '0 : one << (len - 1);
    endfunction

    function automatic logic [WIDTH-1:0] rand_val();
        int r = $urandom_range(0, WIDTH);
        logic [WIDTH-1:0] one = 1;
        logic [WIDTH-1:0] v = {$urandom, $urandom};
        if (r == 0) return '0;
        v = v & ((one << (r - 1)) - one);
        return v | (one << (r - 1));
    endfunction

    // Transaction model: a job accepted in idle yields its result after a fixed cycle count.
    bit               m_busy = 0;
    bit               m_done = 0;
    int               m_rem  = 0;
    int               m_pend = 0;
    logic [LEN_W-1:0] m_len  = '0;
    logic [WIDTH-1:0] m_msb  = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 0; m_done = 0; m_rem = 0; m_len = '0; m_msb = '0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1;
                m_len  = LEN_W'(m_pend);
                m_msb  = onehot_of(m_pend);
            end
        end else if (md_start) begin
            m_busy = 1;
            m_pend = bit_len(num_in);
            m_rem  = chunks_scanned(m_pend);
        end
    end

    always @(negedge clk) begin
        check("md_end", md_end, m_done);
        check("busy", busy, m_busy);
        check("len_out", len_out, m_len);
`ifdef GET_LENGTH_MULTI_ONEHOT_EN
        check("msb_out", msb_out, m_msb);
`endif
        if (md_end) n_pulses++;
    end

    // Starts one operation and returns at the negedge of the md_end cycle.
    task automatic run_one(input logic [WIDTH-1:0] value, input int exp_len, input int exp_k,
                           input bit junk);
        int idx;
        @(negedge clk);
        md_start = 1'b1;
        num_in   = value;
        @(negedge clk);
        if (junk) begin
            md_start = 1'b1;
            num_in   = '1;
        end else begin
            md_start = 1'b0;
            num_in   = {$urandom, $urandom};
        end
        idx = 1;
        while (!md_end && idx < 40) begin
            @(negedge clk);
            idx++;
        end
        check("latency", 64'(idx), 64'(exp_k + 1));
        check("len_lit", 64'(len_out), 64'(exp_len));
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int p0;
        rstn     = 1'b0;
        md_start = 1'b0;
        num_in   = '0;
        repeat (3) @(negedge clk);
        check("rst_len", 64'(len_out), 64'd0);
        check("rst_md_end", 64'(md_end), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rstn = 1'b1;
        settle(2);

        run_one(64'h9, 4, 8, 0);
        run_one(64'h8000_0000_0000_0000, 64, 1, 0);
        settle(2);

        // Zero operand then a back-to-back start in the idle cycle right after done.
        run_one(64'h0, 0, 8, 0);
        run_one(64'h1_0000, 17, 6, 0);
        settle(2);

        // Starts presented while scanning and in done must be ignored.
        p0 = n_pulses;
        run_one(64'hFF00, 16, 7, 1);
        @(negedge clk);
        md_start = 1'b0;
        settle(12);
        check("ignored_start_pulses", 64'(n_pulses - p0), 64'd1);
        check("ignored_start_len", 64'(len_out), 64'd16);

        // Reset in the middle of a scan abandons it silently.
        @(negedge clk);
        md_start = 1'b1;
        num_in   = 64'h1;
        @(negedge clk);
        md_start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("midrst_len", 64'(len_out), 64'd0);
        check("midrst_md_end", 64'(md_end), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        p0 = n_pulses;
        settle(12);
        check("midrst_no_pulse", 64'(n_pulses - p0), 64'd0);
        run_one(64'h3, 2, 8, 0);
        settle(2);

`ifdef GET_LENGTH_MULTI_ONEHOT_EN
        run_one(64'h00F0, 8, 8, 0);
        check("onehot_f0", msb_out, 64'h80);
        run_one(64'h0, 0, 8, 0);
        check("onehot_zero", msb_out, 64'h0);
        settle(2);
`endif

        // Randomized traffic with start noise and occasional asynchronous resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            md_start = ($urandom_range(0, 2) == 0);
            num_in   = rand_val();
            if ($urandom_range(0, 599) == 0) begin
                #1 rstn = 1'b0;
                #2 rstn = 1'b1;
            end
        end
        @(negedge clk);
        md_start = 1'b0;
        settle(NCHUNK + 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
